// File: rtl/twofish_pkg.sv
// Shared types for the Twofish datapath arbiter.
package twofish_pkg;

    typedef logic [127:0] blk_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAITB,
        RUN,
        RESP
    } ctl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin : scan
        logic [IW-1:0] j;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = '0;
        for (int i = 0; i < int'(N); i++) begin
            j = IW'((int'(ptr) + i) % int'(N));
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = j;
            end
        end
    end

endmodule

// File: rtl/twofish_arbiter.sv
// Shares one Twofish datapath between N_REQ requesters: round-robin grant,
// one job in flight, result returned on a shared response bus.
module twofish_arbiter
    import twofish_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  blk_t [N_REQ-1:0]   req_block,
    input  blk_t [N_REQ-1:0]   req_key,
    input  logic [N_REQ-1:0]   req_ende,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output blk_t               rsp_data,
    output logic               rsp_err,
    output blk_t               dp_block,
    output blk_t               dp_key,
    output logic               dp_EnDe,
    output logic               dp_Start,
    input  blk_t               dp_o,
    input  logic               dp_busy
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    ctl_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    blk_t          dp_block_q, dp_block_d;
    blk_t          dp_key_q, dp_key_d;
    logic          dp_ende_q, dp_ende_d;
    blk_t          rsp_data_q, rsp_data_d;
    logic          err_q, err_d;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             any;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        dp_block_d = dp_block_q;
        dp_key_d   = dp_key_q;
        dp_ende_d  = dp_ende_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        req_ready  = '0;
        rsp_valid  = '0;
        dp_Start   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any) begin
                    req_ready  = gnt;
                    dp_block_d = req_block[gnt_idx];
                    dp_key_d   = req_key[gnt_idx];
                    dp_ende_d  = req_ende[gnt_idx];
                    owner_d    = gnt_idx;
                    ptr_d      = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                dp_Start = 1'b1;
                // Counting the first WAITB cycle as 1 makes the timeout fire
                // after exactly TIMEOUT cycles without busy.
                cnt_d    = CW'(1);
                state_d  = WAITB;
            end
            WAITB: begin
                if (dp_busy) begin
                    state_d = RUN;
                end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
                    err_d      = 1'b1;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!dp_busy) begin
                    rsp_data_d = dp_o;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            dp_block_q <= '0;
            dp_key_q   <= '0;
            dp_ende_q  <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            dp_block_q <= dp_block_d;
            dp_key_q   <= dp_key_d;
            dp_ende_q  <= dp_ende_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign dp_block = dp_block_q;
    assign dp_key   = dp_key_q;
    assign dp_EnDe  = dp_ende_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_twofish_arbiter.sv
// Bench for twofish_arbiter: behavioural datapath stand-in, round-robin and
// timing model, and a response scoreboard popped by an independent monitor.
module tb_twofish_arbiter;
    import twofish_pkg::*;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned TIMEOUT = 5;
    localparam blk_t        SALT    = 128'h0123456789abcdeffedcba9876543210;

    typedef logic [0:0] rid_t;
    typedef struct {
        rid_t idx;
        blk_t data;
        logic err;
        int   lat;
        int   gcyc;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [N_REQ-1:0] req_valid = '0;
    logic [N_REQ-1:0] req_ready;
    blk_t [N_REQ-1:0] req_block = '0;
    blk_t [N_REQ-1:0] req_key = '0;
    logic [N_REQ-1:0] req_ende = '0;
    logic [N_REQ-1:0] rsp_valid;
    logic [N_REQ-1:0] rsp_ready = '1;
    blk_t             rsp_data;
    logic             rsp_err;
    blk_t             dp_block, dp_key, dp_o;
    logic             dp_EnDe, dp_Start, dp_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_len = 1;
    int   force_len = 0;
    logic mute = 1'b0;
    logic rand_rdy = 1'b0;
    exp_t sb_q[$];
    rid_t gnt_hist[$];
    rid_t rr_m = '0;
    rid_t exp_g, act_g;
    exp_t e;
    logic lat_done = 1'b0;
    int   start_run = 0;
    blk_t last_data = '0;

    twofish_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_block (req_block),
        .req_key   (req_key),
        .req_ende  (req_ende),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dp_block  (dp_block),
        .dp_key    (dp_key),
        .dp_EnDe   (dp_EnDe),
        .dp_Start  (dp_Start),
        .dp_o      (dp_o),
        .dp_busy   (dp_busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Invertible toy cipher standing in for Twofish; ende=1 undoes ende=0.
    function automatic blk_t cipher(input blk_t b, input blk_t k, input logic ende);
        blk_t ks, t;
        ks = {k[63:0], k[127:64]};
        if (!ende) begin
            t = {b[114:0], b[127:115]} ^ k;
            return t + ks + SALT;
        end
        t = (b - ks - SALT) ^ k;
        return {t[12:0], t[127:13]};
    endfunction

    function automatic blk_t rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Datapath stand-in: busy rises the cycle after Start, lasts busy_len cycles.
    blk_t sb, sk;
    logic se;
    int   rem;
    always @(posedge Clk) begin
        if (Reset) begin
            dp_busy <= 1'b0;
            dp_o    <= '0;
            rem     <= 0;
        end else if (dp_Start && !mute) begin
            dp_busy <= 1'b1;
            rem     <= busy_len;
            sb      <= dp_block;
            sk      <= dp_key;
            se      <= dp_EnDe;
        end else if (dp_busy) begin
            if (rem == 1) begin
                dp_busy <= 1'b0;
                dp_o    <= cipher(sb, sk, se);
            end else begin
                rem <= rem - 1;
            end
        end
    end

    // Monitor: grant model, scoreboard push on grant, pop/compare on response.
    always @(negedge Clk) begin
        if (Reset) begin
            sb_q.delete();
            rr_m      = '0;
            lat_done  = 1'b0;
            start_run = 0;
        end else begin
            if (dp_Start) begin
                start_run++;
            end else if (start_run != 0) begin
                chk("start_width", 128'(start_run), 128'(1));
                start_run = 0;
            end
            if (req_ready != '0) begin
                chk("grant_onehot", 128'($countones(req_ready)), 128'(1));
                chk("grant_when_idle", 128'(sb_q.size()), 128'(0));
                exp_g = req_valid[rr_m] ? rr_m : ~rr_m;
                act_g = req_ready[1] ? 1'b1 : 1'b0;
                chk("grant_idx", 128'(act_g), 128'(exp_g));
                rr_m     = exp_g + 1'b1;
                busy_len = (force_len != 0) ? force_len : int'($urandom_range(1, 6));
                e.idx    = exp_g;
                e.err    = mute;
                e.data   = mute ? '0 : cipher(req_block[exp_g], req_key[exp_g], req_ende[exp_g]);
                e.lat    = mute ? int'(TIMEOUT) + 2 : 3 + busy_len;
                e.gcyc   = cyc;
                sb_q.push_back(e);
                gnt_hist.push_back(act_g);
            end
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_spurious", 128'(rsp_valid), 128'(0));
                end else begin
                    if (!lat_done) begin
                        chk("latency", 128'(cyc - sb_q[0].gcyc), 128'(sb_q[0].lat));
                        lat_done = 1'b1;
                    end
                    if (rsp_ready[sb_q[0].idx]) begin
                        chk("rsp_owner", 128'(rsp_valid), 128'(2'b01 << sb_q[0].idx));
                        chk("rsp_data", rsp_data, sb_q[0].data);
                        chk("rsp_err", 128'(rsp_err), 128'(sb_q[0].err));
                        last_data = rsp_data;
                        void'(sb_q.pop_front());
                        lat_done = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge Clk);
        #1;
        if (rand_rdy) rsp_ready = 2'($urandom);
    end

    task automatic issue(input rid_t i, input blk_t b, input blk_t k, input logic ende);
        int n;
        @(posedge Clk);
        #1;
        req_block[i] = b;
        req_key[i]   = k;
        req_ende[i]  = ende;
        req_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            #1;
            n++;
        end while (!req_ready[i] && n < 500);
        chk("grant_wait", 128'(req_ready[i]), 128'(1));
        @(posedge Clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge Clk);
            #1;
            n++;
        end while ((sb_q.size() != 0 || rsp_valid != '0) && n < 1000);
        chk("idle_wait", 128'(sb_q.size()), 128'(0));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        chk({tag, "_dp_start"}, 128'(dp_Start), 128'(0));
        chk({tag, "_dp_ende"}, 128'(dp_EnDe), 128'(0));
        chk({tag, "_dp_block"}, dp_block, '0);
        chk({tag, "_dp_key"}, dp_key, '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
    endtask

    initial begin
        int   n, bad, gh0;
        blk_t hold, b, k, c;
        rid_t i;

        repeat (3) @(posedge Clk);
        #1;
        reset_checks("rst");
        Reset = 1'b0;

        // Single encrypt, then decrypt of that result by the other requester.
        issue(1'b0, '0, '0, 1'b0);
        wait_idle();
        chk("t1_cipher", last_data, SALT);
        issue(1'b1, last_data, '0, 1'b1);
        wait_idle();
        chk("t2_plain", last_data, '0);

        // Both requesters valid continuously: grants must alternate.
        gh0 = gnt_hist.size();
        req_block = {rnd(), rnd()};
        req_key   = {rnd(), rnd()};
        req_ende  = 2'b01;
        @(posedge Clk);
        #1;
        req_valid = 2'b11;
        n = 0;
        while (gnt_hist.size() < gh0 + 4 && n < 400) begin
            @(negedge Clk);
            #1;
            n++;
        end
        @(posedge Clk);
        #1;
        req_valid = '0;
        wait_idle();
        chk("t3_grants", 128'(gnt_hist.size()), 128'(gh0 + 4));
        for (int j = 0; j < 4; j++) chk("t3_order", 128'(gnt_hist[gh0 + j]), 128'(j % 2));

        // Owner stalls its response for 10 cycles while the other requester waits.
        rsp_ready = 2'b10;
        issue(1'b0, rnd(), rnd(), 1'b0);
        req_block[1] = rnd();
        req_key[1]   = rnd();
        req_ende[1]  = 1'b0;
        req_valid[1] = 1'b1;
        n = 0;
        while (!rsp_valid[0] && n < 100) begin
            @(negedge Clk);
            #1;
            n++;
        end
        chk("t4_rsp_seen", 128'(rsp_valid[0]), 128'(1));
        hold = rsp_data;
        bad  = 0;
        repeat (10) begin
            @(negedge Clk);
            #1;
            if (rsp_valid != 2'b01 || rsp_data !== hold || req_ready != '0) bad++;
        end
        chk("t4_stall_hold", 128'(bad), 128'(0));
        @(posedge Clk);
        #1;
        rsp_ready = 2'b11;
        n = 0;
        while (!req_ready[1] && n < 100) begin
            @(negedge Clk);
            #1;
            n++;
        end
        chk("t4_next_grant", 128'(req_ready[1]), 128'(1));
        @(posedge Clk);
        #1;
        req_valid[1] = 1'b0;
        wait_idle();

        // Datapath never goes busy: timeout response.
        mute = 1'b1;
        issue(1'b1, rnd(), rnd(), 1'b0);
        wait_idle();
        mute = 1'b0;

        // Reset while the datapath is running aborts the job.
        force_len = 6;
        issue(1'b0, rnd(), rnd(), 1'b0);
        n = 0;
        while (!dp_busy && n < 50) begin
            @(negedge Clk);
            #1;
            n++;
        end
        chk("t6_busy_seen", 128'(dp_busy), 128'(1));
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        reset_checks("t6");
        Reset     = 1'b0;
        force_len = 0;
        issue(1'b1, rnd(), rnd(), 1'b0);
        wait_idle();

        // Random encrypt/decrypt round trips with random response back-pressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 100; r++) begin
            i = rid_t'($urandom_range(0, 1));
            b = rnd();
            k = rnd();
            issue(i, b, k, 1'b0);
            wait_idle();
            c = last_data;
            issue(~i, c, k, 1'b1);
            wait_idle();
            chk("roundtrip", last_data, b);
        end
        rand_rdy = 1'b0;
        @(posedge Clk);
        #1;
        rsp_ready = '1;
        repeat (5) @(posedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
